// File: rtl/microbot_nav_fsm_pkg.sv
// -----------------------------------------------------------------------------
// microbot_nav_pkg
// Shared definitions for the microbot navigation controller:
//   - nav_state_e : 3-bit navigation state codes (6 and 7 are unused)
//   - MOT_*       : 2-bit H-bridge drive codes (11 is never driven)
//   - sens_group  : maps a sensor index to its left/centre/right group
// -----------------------------------------------------------------------------
package microbot_nav_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FWD     = 3'd1,
      ST_TURN_L  = 3'd2,
      ST_TURN_R  = 3'd3,
      ST_REVERSE = 3'd4,
      ST_STUCK   = 3'd5
   } nav_state_e;

   localparam logic [1:0] MOT_STOP = 2'b00;
   localparam logic [1:0] MOT_FWD  = 2'b01;
   localparam logic [1:0] MOT_REV  = 2'b10;

   typedef enum logic [1:0] {
      GRP_L,
      GRP_C,
      GRP_R
   } sens_grp_e;

   // Index 0 is the leftmost sensor. The left half is everything below
   // n/2, the right half everything from (n+1)/2 up. With an odd count the
   // single sensor between the halves is the centre sensor; with an even
   // count the halves meet and there is no centre.
   function automatic sens_grp_e sens_group(input int n_sens, input int idx);
      if (idx < n_sens / 2) begin
         return GRP_L;
      end else if (idx >= (n_sens + 1) / 2) begin
         return GRP_R;
      end else begin
         return GRP_C;
      end
   endfunction

endpackage

// File: rtl/microbot_nav_fsm_if.sv
// -----------------------------------------------------------------------------
// microbot_nav_if
// Bundles the run/sensor inputs and motor/status outputs of the navigation
// controller.
//   en        : run enable (0 forces IDLE)
//   sens_raw  : raw obstacle sensors, 1 = obstacle, bit 0 leftmost
//   motor_l/r : H-bridge drive codes
//   state     : current state code
//   stuck     : high while in STUCK
//   retry_cnt : REVERSE entries since the last clear
// master drives en/sens_raw (sensor side), slave is the controller.
// -----------------------------------------------------------------------------
interface microbot_nav_if #(
   parameter int N_SENS    = 3,
   parameter int MAX_RETRY = 3
);
   logic                               en;
   logic [N_SENS-1:0]                  sens_raw;
   logic [1:0]                         motor_l;
   logic [1:0]                         motor_r;
   logic [2:0]                         state;
   logic                               stuck;
   logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt;

   modport master (
      output en, sens_raw,
      input  motor_l, motor_r, state, stuck, retry_cnt
   );

   modport slave (
      input  en, sens_raw,
      output motor_l, motor_r, state, stuck, retry_cnt
   );
endinterface

// File: rtl/microbot_nav_fsm_sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
// Single-bit level debouncer. The filtered output only takes a new raw
// level once it has persisted for DEB_CYCLES consecutive clock edges.
//   clk, rst_n : clock, synchronous active-low reset
//   raw        : unfiltered sensor bit
//   filt       : debounced sensor bit (registered)
// -----------------------------------------------------------------------------
module sensor_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   // Count edges on which raw disagrees with the filtered bit. The edge
   // that would bring the count to DEB_CYCLES copies raw across instead,
   // and any agreement starts the count over.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (raw != filt_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            filt_d = raw;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt = filt_q;

endmodule

// File: rtl/microbot_nav_fsm.sv
// -----------------------------------------------------------------------------
// microbot_nav_fsm
// Obstacle-avoidance navigation controller for N_SENS debounced sensors,
// with timed turn/reverse manoeuvres and a retry limit that latches STUCK.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : microbot_nav_if slave (en, sens_raw in; motor_l, motor_r,
//                state, stuck, retry_cnt out, all registered)
// -----------------------------------------------------------------------------
module microbot_nav_fsm
   import microbot_nav_pkg::*;
#(
   parameter int N_SENS     = 3,
   parameter int DEB_CYCLES = 4,
   parameter int TURN_LEN   = 16,
   parameter int REV_LEN    = 8,
   parameter int CLEAR_LEN  = 32,
   parameter int MAX_RETRY  = 3
) (
   input logic           clk,
   input logic           rst_n,
   microbot_nav_if.slave bus
);

   localparam int MAX_LEN = (TURN_LEN > REV_LEN) ? TURN_LEN : REV_LEN;
   localparam int TW      = $clog2(MAX_LEN + 1);
   localparam int CW      = $clog2(CLEAR_LEN + 1);
   localparam int RW      = $clog2(MAX_RETRY + 1);

   logic [N_SENS-1:0] filt;
   logic              grp_l, grp_c, grp_r, grp_all;

   nav_state_e        state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [CW-1:0]     clr_q, clr_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic [1:0]        mot_l_q, mot_l_d;
   logic [1:0]        mot_r_q, mot_r_d;
   logic              stuck_q, stuck_d;

   logic [RW-1:0]     retry_inc;
   nav_state_e        rev_state;
   logic [TW-1:0]     rev_timer;

   for (genvar g = 0; g < N_SENS; g++) begin : g_deb
      sensor_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (bus.sens_raw[g]),
         .filt  (filt[g])
      );
   end

   // Fold the filtered sensors into left/centre/right obstacle flags.
   always_comb begin
      grp_l = 1'b0;
      grp_c = 1'b0;
      grp_r = 1'b0;
      for (int i = 0; i < N_SENS; i++) begin
         case (sens_group(N_SENS, i))
            GRP_L:   grp_l = grp_l | filt[i];
            GRP_C:   grp_c = grp_c | filt[i];
            GRP_R:   grp_r = grp_r | filt[i];
            default: ;
         endcase
      end
      grp_all = &filt;
   end

   // Entering REVERSE bumps the saturating retry count; the entry that
   // reaches the limit goes to STUCK instead.
   always_comb begin
      retry_inc = (retry_q == RW'(MAX_RETRY)) ? retry_q : retry_q + RW'(1);
      if (retry_inc == RW'(MAX_RETRY)) begin
         rev_state = ST_STUCK;
         rev_timer = '0;
      end else begin
         rev_state = ST_REVERSE;
         rev_timer = TW'(REV_LEN - 1);
      end
   end

   // Next-state logic. Timed states load LEN-1 on entry and leave on the
   // edge that sees the timer at 0. The clear counter only advances on
   // obstacle-free FWD cycles; everything else zeroes it.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      clr_d   = '0;
      retry_d = retry_q;
      if (!bus.en) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_FWD;
               retry_d = '0;
            end
            ST_FWD: begin
               if (grp_c || (grp_l && grp_r)) begin
                  state_d = rev_state;
                  timer_d = rev_timer;
                  retry_d = retry_inc;
               end else if (grp_l) begin
                  state_d = ST_TURN_R;
                  timer_d = TW'(TURN_LEN - 1);
               end else if (grp_r) begin
                  state_d = ST_TURN_L;
                  timer_d = TW'(TURN_LEN - 1);
               end else if (clr_q == CW'(CLEAR_LEN - 1)) begin
                  retry_d = '0;
               end else begin
                  clr_d = clr_q + CW'(1);
               end
            end
            ST_TURN_L, ST_TURN_R: begin
               if (grp_all) begin
                  state_d = rev_state;
                  timer_d = rev_timer;
                  retry_d = retry_inc;
               end else if (timer_q == '0) begin
                  state_d = ST_FWD;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            ST_REVERSE: begin
               if (timer_q == '0) begin
                  state_d = ST_TURN_L;
                  timer_d = TW'(TURN_LEN - 1);
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            ST_STUCK: ;
            default: begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   // Motors and stuck are decoded from the next state so they update on
   // the same edge as the state register.
   always_comb begin
      mot_l_d = MOT_STOP;
      mot_r_d = MOT_STOP;
      case (state_d)
         ST_FWD:     begin mot_l_d = MOT_FWD; mot_r_d = MOT_FWD; end
         ST_TURN_L:  begin mot_l_d = MOT_REV; mot_r_d = MOT_FWD; end
         ST_TURN_R:  begin mot_l_d = MOT_FWD; mot_r_d = MOT_REV; end
         ST_REVERSE: begin mot_l_d = MOT_REV; mot_r_d = MOT_REV; end
         default:    ;
      endcase
      stuck_d = (state_d == ST_STUCK);
   end

   // Single register stage for the FSM and all of its outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         clr_q   <= '0;
         retry_q <= '0;
         mot_l_q <= MOT_STOP;
         mot_r_q <= MOT_STOP;
         stuck_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         clr_q   <= clr_d;
         retry_q <= retry_d;
         mot_l_q <= mot_l_d;
         mot_r_q <= mot_r_d;
         stuck_q <= stuck_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.motor_l   = mot_l_q;
   assign bus.motor_r   = mot_r_q;
   assign bus.stuck     = stuck_q;
   assign bus.retry_cnt = retry_q;

endmodule

// File: doc/microbot_nav_fsm.md
Name: microbot_nav_fsm

Overview:
Parametrised navigation controller for the microbot motor stage. It generalises the fixed 3-sensor obstacle FSM to N obstacle sensors. It adds per-sensor debouncing, timed turn and reverse manoeuvres, and a retry limit that latches a STUCK condition. It sits between the raw sensor pins and the two H-bridge motor drivers.

Parameters:
N_SENS, 3, number of obstacle sensors; index 0 is leftmost, index N_SENS-1 is rightmost; minimum 2.
DEB_CYCLES, 4, consecutive cycles a raw level must persist before the filtered bit takes it; minimum 1.
TURN_LEN, 16, cycles spent in TURN_L or TURN_R; minimum 1.
REV_LEN, 8, cycles spent in REVERSE; minimum 1.
CLEAR_LEN, 32, obstacle-free FWD cycles that clear the retry counter.
MAX_RETRY, 3, REVERSE entries without an intervening clear before STUCK; minimum 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  run enable; 0 forces IDLE
sens_raw  in  N_SENS  raw obstacle sensors, 1 = obstacle
motor_l  out  2  left motor: 00 stop, 01 fwd, 10 rev, 11 never driven
motor_r  out  2  right motor, same encoding
state  out  3  current state code
stuck  out  1  high while in STUCK
retry_cnt  out  $clog2(MAX_RETRY+1)  current retry count

Behaviour:
- Single clock domain. Reset is synchronous and active-low. All outputs and state are registered.
- Reset values: state=IDLE(0), motors=00/00, stuck=0, retry_cnt=0, filtered sensors=0, debounce counters=0, timer=0.
- Debounce, per sensor:
  - A counter increments while raw != filtered and resets to 0 when raw == filtered.
  - When the counter reaches DEB_CYCLES, filtered takes the raw value and the counter resets.
  - Latency: a raw change held for DEB_CYCLES cycles updates filtered; the FSM reacts on the next edge.
  - A shorter glitch never reaches the FSM.
- Sensor groups:
  - L = OR of indices below N_SENS/2 (integer division).
  - R = OR of indices at or above (N_SENS+1)/2.
  - C = index N_SENS/2 when N_SENS is odd; C is constant 0 when N_SENS is even.
  - ALL = AND of all filtered bits.
- State codes: IDLE=0, FWD=1, TURN_L=2, TURN_R=3, REVERSE=4, STUCK=5. Codes 6 and 7 are unused and recover to IDLE.
- Motor map:
  - IDLE and STUCK: 00/00.
  - FWD: 01/01.
  - TURN_L: 10/01.
  - TURN_R: 01/10.
  - REVERSE: 10/10.
- Motors are decoded from next-state and registered, so they change on the same edge as state.
- Transitions, in priority order:
  - en=0: any state goes to IDLE next edge. Timer and clear counter reset. retry_cnt is held, and reset only by rst_n or on IDLE->FWD.
  - IDLE: en=1 goes to FWD and clears retry_cnt.
  - FWD:
    - C, or (L and R), goes to REVERSE.
    - Else L goes to TURN_R.
    - Else R goes to TURN_L.
    - Else stay in FWD.
  - TURN_L/TURN_R: ALL goes to REVERSE immediately. Otherwise stay exactly TURN_LEN cycles, then go to FWD.
  - REVERSE: stay exactly REV_LEN cycles, then go to TURN_L.
  - STUCK: hold until en=0, then go to IDLE.
- Entering REVERSE:
  - retry_cnt increments.
  - If the incremented value equals MAX_RETRY, the next state is STUCK instead of REVERSE.
  - retry_cnt saturates at MAX_RETRY.
- Clear counter: counts consecutive FWD cycles with no obstacle. On reaching CLEAR_LEN it zeroes retry_cnt and resets itself. Any obstacle or leaving FWD resets it.
- Timer:
  - Loaded with LEN-1 on entry to a timed state and decrements each cycle.
  - The exit is taken on the edge where the timer reads 0, so the state is held exactly LEN cycles.
- Reset mid-manoeuvre: rst_n low on any edge restores the reset values the same edge, including debounce state.

Decomposition:
- Package microbot_nav_pkg holds:
  - the state enum (3-bit) and its codes;
  - the motor codes MOT_STOP, MOT_FWD, MOT_REV;
  - a function computing the sensor-group split from N_SENS.
- One sub-module, sensor_debounce, parametrised by DEB_CYCLES. It is instantiated N_SENS times in a generate loop.

Test Plan:
- Reset, then en=1, sens_raw=000 → state=1 (FWD) on the 1st edge after en; motors 01/01; retry_cnt=0.
- FWD, sens_raw=001 held 4 cycles (N=3, DEB=4) → TURN_R 5 edges after the change; motors 01/10 for exactly 16 cycles; then FWD.
- Glitch: sens_raw=010 for 3 cycles only → state stays FWD; filtered never changes.
- sens_raw=010 held → REVERSE (motors 10/10) for 8 cycles, then TURN_L for 16 cycles; retry_cnt=1. Repeating twice more gives STUCK on the 3rd entry with stuck=1 and motors 00/00; en=0 → IDLE.
- During TURN_L, sens_raw=111 held 4 cycles → REVERSE next edge. Separately, 32 clear FWD cycles after retry_cnt=2 → retry_cnt=0.
- rst_n=0 mid-REVERSE with N_SENS=4 (C=0, L=bits[1:0], R=bits[3:2]) → all outputs return to reset values on that edge. After reset, en=1 with sens_raw=0110 gives REVERSE via L and R.
